// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped I-cache miss/refill and flush-serialising controller
// Optional hit/miss counters are enabled by defining CACHE_REFILL_STATS_EN.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iReqValid,
  input  logic [ADDR_WIDTH-1:0]  iReqAddress,
  output logic                   oReqReady,
  output logic                   oRespValid,
  output logic [DATA_WIDTH-1:0]  oRespData,
  output logic [ADDR_WIDTH-1:0]  oLookupAddress,
  input  logic                   iHit,
  input  logic [DATA_WIDTH-1:0]  iCacheData,
  output logic                   oWrEn,
  output logic [INDEX_WIDTH-1:0] oWrIndex,
  output logic [TAG_WIDTH-1:0]   oWrTag,
  output logic                   oWrValid,
  output logic [DATA_WIDTH-1:0]  oWrData,
  input  logic                   iFlush,
  input  logic [ADDR_WIDTH-1:0]  iFlushAddress,
  output logic                   oMemReqValid,
  output logic [ADDR_WIDTH-1:0]  oMemAddress,
  input  logic                   iMemReqReady,
  input  logic                   iMemRespValid,
  input  logic [DATA_WIDTH-1:0]  iMemRespData
`ifdef CACHE_REFILL_STATS_EN
  ,
  output logic [31:0]            oHitCount,
  output logic [31:0]            oMissCount
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, FLUSH} state_e;

  state_e                 state_q;
  logic                   flush_pend_q;
  logic [INDEX_WIDTH-1:0] flush_idx_q;
  logic [INDEX_WIDTH-1:0] flush_idx_d;
  logic [ADDR_WIDTH-1:0]  lookup_addr_q;
  logic                   resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_data_q;
  logic                   wr_en_q;
  logic                   wr_valid_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [TAG_WIDTH-1:0]   wr_tag_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic                   mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic                   unused_flush_bits;

  assign unused_flush_bits = ^{iFlushAddress[ADDR_WIDTH-1:INDEX_WIDTH+2], iFlushAddress[1:0]};

  // An incoming flush is newer than any pending one, so its set takes priority.
  always_comb begin
    flush_idx_d = flush_idx_q;
    if (iFlush) flush_idx_d = iFlushAddress[INDEX_WIDTH+1:2];
  end

  assign oReqReady      = iRst && (state_q == IDLE) && !flush_pend_q && !iFlush;
  assign oRespValid     = resp_valid_q;
  assign oRespData      = resp_data_q;
  assign oLookupAddress = lookup_addr_q;
  assign oWrEn          = wr_en_q;
  assign oWrValid       = wr_valid_q;
  assign oWrIndex       = wr_index_q;
  assign oWrTag         = wr_tag_q;
  assign oWrData        = wr_data_q;
  assign oMemReqValid   = mem_req_valid_q;
  assign oMemAddress    = mem_addr_q;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q         <= IDLE;
      flush_pend_q    <= 1'b0;
      flush_idx_q     <= '0;
      lookup_addr_q   <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      wr_en_q         <= 1'b0;
      wr_valid_q      <= 1'b0;
      wr_index_q      <= '0;
      wr_tag_q        <= '0;
      wr_data_q       <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      if (iFlush && state_q != IDLE) begin
        flush_pend_q <= 1'b1;
        flush_idx_q  <= iFlushAddress[INDEX_WIDTH+1:2];
      end
      case (state_q)
        IDLE: begin
          if (flush_pend_q || iFlush) begin
            flush_pend_q <= 1'b0;
            wr_en_q      <= 1'b1;
            wr_index_q   <= flush_idx_d;
            wr_tag_q     <= '0;
            wr_data_q    <= '0;
            state_q      <= FLUSH;
          end else if (iReqValid) begin
            lookup_addr_q <= iReqAddress;
            state_q       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (iHit) begin
            resp_data_q  <= iCacheData;
            resp_valid_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= {lookup_addr_q[ADDR_WIDTH-1:2], 2'b00};
            state_q         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (iMemReqReady) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (iMemRespValid) begin
            wr_en_q      <= 1'b1;
            wr_valid_q   <= 1'b1;
            wr_index_q   <= lookup_addr_q[INDEX_WIDTH+1:2];
            wr_tag_q     <= lookup_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
            wr_data_q    <= iMemRespData;
            resp_valid_q <= 1'b1;
            resp_data_q  <= iMemRespData;
            state_q      <= FILL;
          end
        end
        FILL:    state_q <= IDLE;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_REFILL_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (iHit && hit_cnt_q != 32'hFFFF_FFFF)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      else if (!iHit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign oHitCount  = hit_cnt_q;
  assign oMissCount = miss_cnt_q;
`endif

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling and refill controller sitting directly downstream of the direct-mapped instruction-cache lookup (decode, tag/data array, hit detect). Accepts word requests, consumes the lookup's hit flag and data, and on a miss fetches the word from main memory over a valid/ready port. It then writes tag, valid and data back into the array and returns the word. Also serialises flush requests into single-line invalidations.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width (one word per line)
- INDEX_WIDTH, 4, set index bits (16 sets)
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-2 (26), tag bits; address = {tag, index, 2'b00}

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-low
- iReqValid  in  1  requester presents an address
- iReqAddress  in  ADDR_WIDTH  requested byte address
- oReqReady  out  1  controller accepts a request this cycle
- oRespValid  out  1  one-cycle pulse, oRespData valid
- oRespData  out  DATA_WIDTH  returned word
- oLookupAddress  out  ADDR_WIDTH  latched address driven to the lookup stage
- iHit  in  1  hit flag from lookup, valid in LOOKUP
- iCacheData  in  DATA_WIDTH  array data, valid in LOOKUP
- oWrEn  out  1  array write strobe
- oWrIndex  out  INDEX_WIDTH  set written
- oWrTag  out  TAG_WIDTH  tag written
- oWrValid  out  1  valid bit written (0 = invalidate)
- oWrData  out  DATA_WIDTH  data written
- iFlush  in  1  invalidate the line at iFlushAddress
- iFlushAddress  in  ADDR_WIDTH  address whose set is invalidated
- oMemReqValid  out  1  memory read request
- oMemAddress  out  ADDR_WIDTH  word-aligned read address
- iMemReqReady  in  1  memory accepts request
- iMemRespValid  in  1  memory read data valid
- iMemRespData  in  DATA_WIDTH  memory read data

## Operation
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, FLUSH.
- IDLE: oReqReady = 1 only if no flush is pending and iFlush = 0. A pending or incoming flush goes to FLUSH. Otherwise, iReqValid && oReqReady latches the address into oLookupAddress and goes to LOOKUP.
- LOOKUP: sample iHit. On a hit, register iCacheData into oRespData, pulse oRespValid next cycle, and go to IDLE. On a miss, go to MEM_REQ.
- MEM_REQ: oMemReqValid = 1, oMemAddress = {latched tag, latched index, 2'b00}; both held stable until iMemReqReady. Then go to MEM_WAIT.
- MEM_WAIT: on iMemRespValid, capture iMemRespData and go to FILL. iMemRespValid in any other state is ignored.
- FILL, one cycle: oWrEn = 1, oWrValid = 1, tag/index/data from the latched request and captured word. Same cycle: oRespValid = 1, oRespData = captured word. Then go to IDLE.
- FLUSH, one cycle: oWrEn = 1, oWrValid = 0, oWrIndex = flush index, oWrTag = 0, oWrData = 0. Clears the pending flag, then go to IDLE.
- Flush arriving outside IDLE: latched into a one-deep pending register with its address; a later flush before service overwrites it. Serviced before the next request is accepted, so an in-flight fill to the same set is invalidated afterwards.
- iFlush and iReqValid together in IDLE: flush wins; the request is not accepted (oReqReady = 0).
- Reset (async, any state): state to IDLE, pending flush cleared. oRespValid, oWrEn, oWrValid, oMemReqValid = 0. oRespData, oLookupAddress, oWrIndex, oWrTag, oWrData, oMemAddress = 0. oReqReady = 0 while iRst is low. An outstanding memory response after reset release is ignored.

## Timing
- Accept at edge 0. LOOKUP during cycle 1. A hit sets oRespValid high during cycle 2, and a new request can be accepted at edge 2.
- Miss with iMemReqReady = 1 immediately: MEM_REQ cycle 2, MEM_WAIT from cycle 3. A response at cycle k gives FILL and oRespValid at cycle k+1, and the next accept at edge k+2.
- FLUSH costs exactly one cycle.
- oReqReady is combinational from state, pending flag and iFlush. All other outputs are registered or decoded from state.

## Configuration
- CACHE_REFILL_STATS_EN defined: adds ports oHitCount and oMissCount (out, 32 bits each), both reset to 0.
  - oHitCount increments on each LOOKUP hit; oMissCount on each LOOKUP miss.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: ports and counters absent. Behaviour otherwise identical.

## Test plan
- After reset release, request 0x0000_0040 with iHit = 1, iCacheData = 0xDEAD_BEEF -> oRespValid during cycle 2 with 0xDEAD_BEEF; no memory request.
- Request 0x1234_5678 with iHit = 0, iMemReqReady delayed 3 cycles, response 0xCAFE_F00D after 5 cycles -> oMemAddress 0x1234_5678 held stable throughout; FILL writes index 0xE, tag 0x048D159, data 0xCAFE_F00D, valid 1; oRespValid simultaneous with 0xCAFE_F00D.
- iFlush with address 0x0000_0084 during MEM_WAIT -> fill completes first, then one FLUSH cycle with oWrIndex 0x1, oWrValid 0; oReqReady held 0 until FLUSH ends.
- iFlush and iReqValid in the same IDLE cycle -> FLUSH first, request accepted the cycle after.
- iRst low during MEM_REQ, then a stray iMemRespValid -> all outputs 0, IDLE, response ignored, no write.
- With CACHE_REFILL_STATS_EN: 3 hits, 2 misses -> oHitCount = 3, oMissCount = 2.
